card_hand_display: RTL and testbench

//  Registered hand store for one baccarat hand: accepts dealt card codes one per load strobe,

---
 rtl/card_hand_display.sv | 115 +++++++++++
 tb/tb_card_hand_display.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/card_hand_display.sv
// Baccarat hand store: up to NSLOTS dealt cards, a 7-seg digit per slot,
// a running mod-10 score, and an optional blink on the most recently dealt card.
module card_digit (
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (code)
        4'd1:    seg = 7'b0001000;
        4'd2:    seg = 7'b0100100;
        4'd3:    seg = 7'b0110000;
        4'd4:    seg = 7'b0011001;
        4'd5:    seg = 7'b0010010;
        4'd6:    seg = 7'b0000010;
        4'd7:    seg = 7'b1111000;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0010000;
        4'd10:   seg = 7'b1000000;
        4'd11:   seg = 7'b1100001;
        4'd12:   seg = 7'b0011000;
        4'd13:   seg = 7'b0001001;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module card_hand_display #(
  parameter int NSLOTS    = 3,
  parameter int BLINK_EN  = 1,
  parameter int BLINK_DIV = 25
) (
  input  logic                          slow_clock,
  input  logic                          resetb,
  input  logic                          clear,
  input  logic                          load_card,
  input  logic [3:0]                    card_in,
  output logic [7*NSLOTS-1:0]           hex_out,
  output logic [3:0]                    score,
  output logic [$clog2(NSLOTS+1)-1:0]   count,
  output logic                          full,
  output logic                          err
);
  localparam int CW = $clog2(NSLOTS+1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [NSLOTS-1:0][3:0] slots;
  logic [BW-1:0]          bcnt;
  logic                   phase_on;
  logic                   valid_code, accept, reject;
  logic [3:0]             value;
  logic [4:0]             sum5;
  logic [3:0]             nscore;

  assign full       = (count == CW'(NSLOTS));
  assign valid_code = (card_in >= 4'd1) && (card_in <= 4'd13);
  assign accept     = load_card && !clear && !full && valid_code;
  assign reject     = load_card && !clear && !accept;
  // 10/J/Q/K are worth nothing in baccarat
  assign value      = (card_in <= 4'd9) ? card_in : 4'd0;
  assign sum5       = {1'b0, score} + {1'b0, value};
  assign nscore     = (sum5 >= 5'd10) ? 4'(sum5 - 5'd10) : sum5[3:0];

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slots    <= '0;
      count    <= '0;
      score    <= '0;
      err      <= 1'b0;
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (clear) begin
      slots    <= '0;
      count    <= '0;
      score    <= '0;
      err      <= 1'b0;
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else begin
      err <= reject;
      if (accept) begin
        for (int i = 0; i < NSLOTS; i++)
          if (count == CW'(i)) slots[i] <= card_in;
        count <= count + 1'b1;
        score <= nscore;
      end
      // A fresh card always starts its blink in the visible phase
      if (accept) begin
        bcnt     <= '0;
        phase_on <= 1'b1;
      end else if (BLINK_EN == 0 || count == '0) begin
        bcnt     <= '0;
        phase_on <= 1'b1;
      end else if (bcnt == BW'(BLINK_DIV-1)) begin
        bcnt     <= '0;
        phase_on <= !phase_on;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NSLOTS; i++) begin : g_dig
    logic blank;
    assign blank = (BLINK_EN != 0) && !phase_on && (count == CW'(i+1));
    card_digit u_dig (
      .code  (slots[i]),
      .blank (blank),
      .seg   (hex_out[7*i +: 7])
    );
  end
endmodule

// File: tb/tb_card_hand_display.sv
// Bench for card_hand_display: a steady instance and a blinking instance (BLINK_DIV=4)
// share stimulus; a hand-level model checks both every cycle, literals pin the model.
module tb_card_hand_display;
  logic        slow_clock = 0;
  logic        resetb     = 0;
  logic        clear      = 0;
  logic        load_card  = 0;
  logic [3:0]  card_in    = 0;
  logic [20:0] hex0, hex1;
  logic [3:0]  score0, score1;
  logic [1:0]  count0, count1;
  logic        full0, full1, err0, err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 slow_clock = ~slow_clock;

  card_hand_display #(.NSLOTS(3), .BLINK_EN(0), .BLINK_DIV(4)) dut0 (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear), .load_card(load_card),
    .card_in(card_in), .hex_out(hex0), .score(score0), .count(count0),
    .full(full0), .err(err0));

  card_hand_display #(.NSLOTS(3), .BLINK_EN(1), .BLINK_DIV(4)) dut1 (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear), .load_card(load_card),
    .card_in(card_in), .hex_out(hex1), .score(score1), .count(count1),
    .full(full1), .err(err1));

  // Model: the hand as a list of cards, score as plain sum mod 10, blink from
  // cycles elapsed since the last restart.
  int  q[$];
  int  mscore;
  bit  merr;
  int  age;
  bit  macc;

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      q.delete(); mscore = 0; merr = 0; age = 0;
    end else if (clear) begin
      q.delete(); mscore = 0; merr = 0; age = 0;
    end else begin
      macc = load_card && q.size() < 3 && card_in >= 1 && card_in <= 13;
      merr = load_card && !macc;
      if (macc) begin
        q.push_back(int'(card_in));
        mscore = (mscore + (card_in <= 9 ? int'(card_in) : 0)) % 10;
        age = 0;
      end else if (q.size() > 0) begin
        age++;
      end
    end
  end

  function automatic logic [6:0] seg_of(int c);
    case (c)
      1: return 7'b0001000;   2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;
      7: return 7'b1111000;   8: return 7'b0000000;   9: return 7'b0010000;
      10: return 7'b1000000; 11: return 7'b1100001;  12: return 7'b0011000;
      13: return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] exp_hex(bit blink);
    logic [20:0] h;
    bit off;
    off = blink && q.size() > 0 && ((age / 4) % 2 == 1);
    for (int i = 0; i < 3; i++) begin
      if (i < q.size() && !(off && i == q.size() - 1)) h[7*i +: 7] = seg_of(q[i]);
      else h[7*i +: 7] = 7'b1111111;
    end
    return h;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge slow_clock) begin
    chk("m_hex0",   32'(hex0),   32'(exp_hex(0)));
    chk("m_hex1",   32'(hex1),   32'(exp_hex(1)));
    chk("m_score0", 32'(score0), 32'(mscore));
    chk("m_score1", 32'(score1), 32'(mscore));
    chk("m_count0", 32'(count0), 32'(q.size()));
    chk("m_count1", 32'(count1), 32'(q.size()));
    chk("m_full",   32'({full0, full1}), 32'(q.size() == 3 ? 2'b11 : 2'b00));
    chk("m_err",    32'({err0, err1}),   32'(merr ? 2'b11 : 2'b00));
  end

  // Each call ends 2 time units after the edge that consumed the strobe
  task automatic load(input logic [3:0] c);
    @(posedge slow_clock); #2;
    load_card = 1; card_in = c;
    @(posedge slow_clock); #2;
    load_card = 0; card_in = 0;
  endtask

  task automatic do_clear();
    @(posedge slow_clock); #2;
    clear = 1;
    @(posedge slow_clock); #2;
    clear = 0;
  endtask

  initial begin
    // 1: reset
    #3;
    chk("rst_hex",   32'(hex0),  32'h1FFFFF);
    chk("rst_score", 32'(score0), 0);
    chk("rst_count", 32'(count0), 0);
    chk("rst_full",  32'(full0),  0);
    chk("rst_err",   32'(err0),   0);
    #19 resetb = 1;

    // 2: three loads on the steady instance
    load(4'd7);
    chk("l7_dig", 32'(hex0[6:0]), 32'(7'b1111000));
    chk("l7_score", 32'(score0), 7);
    load(4'd12);
    chk("lq_dig", 32'(hex0[13:7]), 32'(7'b0011000));
    chk("lq_score", 32'(score0), 7);
    load(4'd5);
    chk("l5_hex", 32'(hex0), 32'({7'b0010010, 7'b0011000, 7'b1111000}));
    chk("l5_score", 32'(score0), 2);
    chk("l5_full", 32'(full0), 1);

    // 3: reject when full
    load(4'd1);
    chk("full_err1", 32'(err0), 1);
    chk("full_cnt",  32'(count0), 3);
    chk("full_hex",  32'(hex0), 32'({7'b0010010, 7'b0011000, 7'b1111000}));
    @(posedge slow_clock); #2;
    chk("full_err0", 32'(err0), 0);

    // 4: invalid codes on empty hand
    do_clear();
    load(4'd0);  chk("inv0_err",  32'(err0), 1);
    load(4'd14); chk("inv14_err", 32'(err0), 1);
    load(4'd15); chk("inv15_err", 32'(err0), 1);
    chk("inv_cnt", 32'(count0), 0);
    chk("inv_hex", 32'(hex0), 32'h1FFFFF);

    // 5: blink, DIV=4
    do_clear();
    load(4'd9);
    chk("bl_c1", 32'(hex1[6:0]), 32'(7'b0010000));
    repeat (3) @(posedge slow_clock);
    #2 chk("bl_c4", 32'(hex1[6:0]), 32'(7'b0010000));
    @(posedge slow_clock);
    #2 chk("bl_c5", 32'(hex1[6:0]), 32'(7'b1111111));
    chk("bl_steady", 32'(hex0[6:0]), 32'(7'b0010000));
    load(4'd1);
    chk("bl_new_s0", 32'(hex1[6:0]),  32'(7'b0010000));
    chk("bl_new_s1", 32'(hex1[13:7]), 32'(7'b0001000));
    repeat (12) @(posedge slow_clock);
    #2;

    // 6: clear with simultaneous load, then async reset mid-hand
    @(posedge slow_clock); #2;
    clear = 1; load_card = 1; card_in = 4'd3;
    @(posedge slow_clock); #2;
    clear = 0; load_card = 0; card_in = 0;
    chk("cl_cnt",   32'(count0), 0);
    chk("cl_score", 32'(score0), 0);
    chk("cl_err",   32'(err0 | err1), 0);
    load(4'd4);
    load(4'd6);
    chk("h_score", 32'(score1), 0);
    repeat (5) @(posedge slow_clock);
    #1 resetb = 0;
    #1;
    chk("ar_hex0", 32'(hex0), 32'h1FFFFF);
    chk("ar_hex1", 32'(hex1), 32'h1FFFFF);
    chk("ar_cnt",  32'(count1), 0);
    chk("ar_score", 32'(score1), 0);
    resetb = 1;
    load(4'd8);
    load(4'd13);
    repeat (10) @(posedge slow_clock);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
